// File: rtl/obstacle_speed_ctrl_if.sv
// rtl/obstacle_speed_ctrl_if.sv - game-pulse inputs and obstacle step outputs of the speed controller
interface obstacle_speed_ctrl_if;
   logic       i_game_tick;
   logic       i_game_start;
   logic       i_game_over;
   logic       i_game_frozen;
   logic       o_step_valid;
   logic [2:0] o_step_px;
   logic [3:0] o_level;
   logic [7:0] o_speed;
   logic       o_running;

   modport master (
      output i_game_tick, i_game_start, i_game_over, i_game_frozen,
      input  o_step_valid, o_step_px, o_level, o_speed, o_running
   );

   modport slave (
      input  i_game_tick, i_game_start, i_game_over, i_game_frozen,
      output o_step_valid, o_step_px, o_level, o_speed, o_running
   );
endinterface

// File: rtl/obstacle_speed_ctrl.sv
// rtl/obstacle_speed_ctrl.sv - per-tick obstacle scroll step with level-based fixed-point speed ramp
module obstacle_speed_ctrl #(
   parameter int FRAC_BITS   = 4,
   parameter int BASE_SPEED  = 16,
   parameter int SPEED_INC   = 4,
   parameter int MAX_LEVEL   = 15,
   parameter int LEVEL_TICKS = 600
) (
   input  logic                 clk,
   input  logic                 rst_n,
   obstacle_speed_ctrl_if.slave bus
);

   localparam int CNT_W = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t               state;
   logic [FRAC_BITS-1:0] acc_frac;
   logic [CNT_W-1:0]     tick_cnt;
   logic [7:0]           sum;
   logic                 step_ok;
   logic                 level_wrap;

   always_comb begin
      sum        = 8'(acc_frac) + bus.o_speed;
      // Ticks coincident with any game pulse are dropped, as are frozen ticks.
      step_ok    = (state == RUN) && bus.i_game_tick && !bus.i_game_frozen
                   && !bus.i_game_start && !bus.i_game_over;
      level_wrap = (tick_cnt == CNT_W'(LEVEL_TICKS - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         acc_frac         <= '0;
         tick_cnt         <= '0;
         bus.o_level      <= 4'd0;
         bus.o_step_valid <= 1'b0;
         bus.o_step_px    <= 3'd0;
         bus.o_speed      <= 8'(BASE_SPEED);
         bus.o_running    <= 1'b0;
      end else begin
         bus.o_step_valid <= 1'b0;
         // Speed follows the level one cycle later; a wrapping tick still uses the old speed.
         bus.o_speed      <= 8'(BASE_SPEED + int'(bus.o_level) * SPEED_INC);
         case (state)
            IDLE, OVER: begin
               if (bus.i_game_start) begin
                  state         <= RUN;
                  bus.o_running <= 1'b1;
                  acc_frac      <= '0;
                  tick_cnt      <= '0;
                  bus.o_level   <= 4'd0;
               end
            end
            RUN: begin
               if (bus.i_game_over) begin
                  state         <= OVER;
                  bus.o_running <= 1'b0;
               end else if (step_ok) begin
                  bus.o_step_valid <= 1'b1;
                  bus.o_step_px    <= sum[FRAC_BITS+2:FRAC_BITS];
                  acc_frac         <= sum[FRAC_BITS-1:0];
                  if (level_wrap) begin
                     tick_cnt <= '0;
                     if (bus.o_level != 4'(MAX_LEVEL))
                        bus.o_level <= bus.o_level + 4'd1;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state         <= IDLE;
               bus.o_running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/obstacle_speed_ctrl.md
Name: obstacle_speed_ctrl

Overview:
- Sequences the obstacle scroll datapath: decides how many pixels the obstacles advance on each 60 Hz game tick.
- Speed ramps up in discrete levels as play time accumulates; fractional speeds are handled by a fixed-point accumulator.
- Sits between the graphics tick / player_controller game-state pulses and the obstacles block; replaces its fixed 1 px/tick stepping.
- Runs entirely on the system clock; ticks and game pulses are single-cycle clk-domain strobes.

Parameters:
- FRAC_BITS, 4, fractional bits of speed/accumulator (speed unit = 1/16 px per tick).
- BASE_SPEED, 16, level-0 speed in fixed point (1.0 px/tick).
- SPEED_INC, 4, speed added per level (0.25 px/tick).
- MAX_LEVEL, 15, level saturation value.
- LEVEL_TICKS, 600, running ticks per level increment (10 s at 60 Hz).
- Legality constraint: BASE_SPEED + MAX_LEVEL*SPEED_INC + 2^FRAC_BITS - 1 < 128.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- i_game_tick, input, 1, one-cycle 60 Hz frame tick.
- i_game_start, input, 1, one-cycle game start pulse.
- i_game_over, input, 1, one-cycle game over pulse.
- i_game_frozen, input, 1, level high while game is paused/frozen.
- o_step_valid, output, 1, one-cycle strobe: obstacles advance by o_step_px this frame.
- o_step_px, output, 3, pixels to advance (0..7); held between strobes.
- o_level, output, 4, current speed level.
- o_speed, output, 8, current speed, fixed point Q3.FRAC_BITS.
- o_running, output, 1, high in RUN state.

Behaviour:
- Reset (async, rst_n low) values:
  - state = IDLE.
  - acc_frac = 0, tick_cnt = 0, o_level = 0.
  - o_step_valid = 0, o_step_px = 0.
  - o_speed = BASE_SPEED, o_running = 0.
- FSM states: IDLE, RUN, OVER.
  - IDLE -> RUN on i_game_start.
  - RUN -> OVER on i_game_over.
  - OVER -> RUN on i_game_start.
  - No other transitions.
- Entering RUN, from IDLE or OVER: on the same edge, clear acc_frac, tick_cnt and o_level to 0.
- Speed: o_speed = BASE_SPEED + o_level*SPEED_INC, 8-bit unsigned, registered. It updates the cycle after o_level changes.
- Step generation: only in RUN, with i_game_tick=1, i_game_frozen=0, and no start/over pulse that cycle.
  - sum = acc_frac + o_speed, 8-bit.
  - Next edge: o_step_px <= sum[FRAC_BITS+2:FRAC_BITS]; acc_frac <= sum[FRAC_BITS-1:0]; o_step_valid <= 1.
  - Latency: strobe appears exactly one cycle after the tick and is one cycle wide.
- Level ramp: on each qualifying tick, tick_cnt increments.
  - When tick_cnt == LEVEL_TICKS-1, tick_cnt wraps to 0 and o_level increments.
  - o_level saturates at MAX_LEVEL; tick_cnt keeps wrapping.
  - The step computed on the wrapping tick uses the old speed.
- Frozen: i_game_frozen=1 in RUN suppresses step, tick_cnt and acc update. State is retained, so the game resumes seamlessly.
- IDLE/OVER: ticks ignored; o_step_valid stays 0. o_level, o_speed and o_step_px hold their last values, so o_level shows the final level after game over.
- Simultaneous events:
  - i_game_over and i_game_start in the same cycle in RUN: game_over wins (-> OVER).
  - The same pair in IDLE/OVER: start wins.
  - Tick coincident with any start/over pulse: tick ignored.
- o_running = (state == RUN), registered with the state.
- Reset mid-game: immediate return to reset values regardless of state; a pending strobe is dropped.
- o_step_px never exceeds 5 under the legality constraint; no overflow handling is required.

Test Plan:
- Reset, start, 20 ticks at level 0 -> 20 strobes, each o_step_px=1, one cycle after its tick; acc_frac stays 0.
- Force o_level=2 (LEVEL_TICKS=4 bench override), speed 24 -> strobes alternate o_step_px 1,2,1,2; 10 ticks total 15 px.
- Run 4*MAX_LEVEL+8 ticks with LEVEL_TICKS=4 -> o_level reaches 15 and holds; o_speed=76; steps cycle 4,5,5,5 (19 px per 4 ticks).
- In RUN, assert i_game_frozen across 5 ticks -> no strobes, tick_cnt/acc unchanged; after release the first step matches the pre-freeze sequence.
- i_game_over and i_game_start in the same cycle while running -> state OVER, o_running=0, o_level held. A later start -> RUN with o_level=0, o_speed=16.
- Pulse rst_n low asynchronously mid-cycle during RUN, coincident with a tick -> all outputs at reset values immediately; no strobe follows.
